// File: rtl/serializer_pkg.sv
// Shared types and sizing helpers for the PISO serializer.
// The PARITY state is only reachable when SERIALIZER_PARITY_EN is defined.
package serializer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    // Bits needed to hold WIDTH-1. The result is never below 1.
    function automatic int bit_cnt_w(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

    // Bits needed to hold DIV-1. DIV=1 still gets a 1-bit counter.
    function automatic int div_cnt_w(input int div);
        return (div > 2) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/piso_serializer_bit_timer.sv
// Per-bit hold timer: counts DIV cycles for each serial bit.
// first marks the opening cycle of a bit and last marks its closing cycle.
module bit_timer
    import serializer_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic enable,
    output logic first,
    output logic last
);

    localparam int DW = div_cnt_w(DIV);
    localparam logic [DW-1:0] RELOAD = DW'(DIV - 1);

    logic [DW-1:0] div_cnt;

    // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (load || (enable && div_cnt == '0)) begin
            div_cnt <= RELOAD;
        end else if (enable) begin
            div_cnt <= div_cnt - DW'(1);
        end
    end

    // With DIV=1 the counter only ever holds 0, so both flags stay high.
    assign first = (div_cnt == RELOAD);
    assign last  = (div_cnt == '0);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter, MSB first, with frame and per-bit strobe.
// Define SERIALIZER_PARITY_EN to append an even-parity bit after the LSB.
module piso_serializer
    import serializer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sdata,
    output logic             sframe,
    output logic             sbit_strobe,
    output logic             busy
);

    localparam int BW = bit_cnt_w(WIDTH);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [BW-1:0]    bit_cnt;
    logic             accept;
    logic             bit_first;
    logic             bit_last;

    assign accept = (state == IDLE) && in_valid;

    bit_timer #(
        .DIV (DIV)
    ) u_bit_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (accept),
        .enable (state != IDLE),
        .first  (bit_first),
        .last   (bit_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (in_valid) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (bit_last && bit_cnt == '0) begin
`ifdef SERIALIZER_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = IDLE;
`endif
                end
            end
`ifdef SERIALIZER_PARITY_EN
            PARITY: begin
                if (bit_last) state_nxt = IDLE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: the shift register is a handful of flops, not a RAM, so it is reset with everything else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (accept) begin
            shreg   <= data_in;
            bit_cnt <= BIT_LAST;
        end else if (state == SHIFT && bit_last && bit_cnt != '0) begin
            shreg   <= {shreg[WIDTH-2:0], 1'b0};
            bit_cnt <= bit_cnt - BW'(1);
        end
    end

`ifdef SERIALIZER_PARITY_EN
    logic parity_q;

    // Parity of the whole word is captured at the handshake, before shifting destroys it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else if (accept) begin
            parity_q <= ^data_in;
        end
    end
`endif

    // Outputs depend only on registered state, never directly on in_valid.
    always_comb begin
        in_ready    = 1'b0;
        sdata       = 1'b0;
        sframe      = 1'b0;
        sbit_strobe = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
            end
            SHIFT: begin
                sdata       = shreg[WIDTH-1];
                sframe      = 1'b1;
                sbit_strobe = bit_first;
            end
`ifdef SERIALIZER_PARITY_EN
            PARITY: begin
                sdata       = parity_q;
                sframe      = 1'b1;
                sbit_strobe = bit_first;
            end
`endif
            default: ;
        endcase
    end

    assign busy = sframe;

endmodule
